univ_shift_reg: RTL and testbench

Parametrised universal register with a synchronous enable. It supports parallel load, hold, clear, logical and arithmetic shifts, and rotates. It also has a multi-cycle "shift by N" sequencer with busy/done status. It is the next-generation storage element for datapath and serial-conversion blocks, replacing the fixed 4-bit load-enable register.

---
 rtl/univ_shift_reg.sv | 147 ++++++++++++++
 tb/tb_univ_shift_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register with a multi-cycle "shift by N" sequencer.
//
// Single-step operations (hold, load, logical/arithmetic shifts, rotates, clear) take effect
// on every enabled edge while the sequencer is idle. A start request with a shift-type mode
// latches the mode and step count, then performs one step per enabled edge until the count
// is exhausted, raising busy for the duration and pulsing done for one cycle at the end.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset (priority over everything)
//   en        operation enable; 0 holds q and pauses a running sequence
//   mode      operation select (hold/load/shl/shr/rotl/rotr/ashr/clear)
//   d         parallel load data
//   sin_l     serial input shifted into the MSB on shr
//   sin_r     serial input shifted into the LSB on shl
//   start     request a multi-cycle shift of amt steps
//   amt       step count for a multi-cycle shift
//   q         register contents
//   sout_msb  q[WIDTH-1]
//   sout_lsb  q[0]
//   busy      multi-cycle shift in progress
//   done      one-cycle pulse when a multi-cycle shift completes
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ModeHold  = 3'b000;
  localparam logic [2:0] ModeLoad  = 3'b001;
  localparam logic [2:0] ModeShl   = 3'b010;
  localparam logic [2:0] ModeShr   = 3'b011;
  localparam logic [2:0] ModeRotl  = 3'b100;
  localparam logic [2:0] ModeRotr  = 3'b101;
  localparam logic [2:0] ModeAshr  = 3'b110;
  localparam logic [2:0] ModeClear = 3'b111;

  localparam logic [AMT_W-1:0] CntZero = '0;
  localparam logic [AMT_W-1:0] CntOne  = AMT_W'(1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [AMT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             busy_q;
  logic             done_q;

  // One step of any non-load operation applied to the current contents.
  function automatic logic [WIDTH-1:0] step_op(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] cur,
                                               input logic             sl,
                                               input logic             sr);
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      ModeShl:   res = {cur[WIDTH-2:0], sr};
      ModeShr:   res = {sl, cur[WIDTH-1:1]};
      ModeRotl:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ModeRotr:  res = {cur[0], cur[WIDTH-1:1]};
      ModeAshr:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      ModeClear: res = '0;
      default:   res = cur;
    endcase
    return res;
  endfunction

  // Only the five shift/rotate modes can launch a multi-cycle sequence.
  logic is_shift_mode;
  assign is_shift_mode = (mode >= ModeShl) && (mode <= ModeAshr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      op_q    <= ModeHold;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only a completing edge re-asserts it.
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) begin
            if (start && is_shift_mode) begin
              // Latch edge: q is untouched, stepping begins on the next enabled edge.
              op_q  <= mode;
              cnt_q <= amt;
              if (amt == CntZero) begin
                done_q <= 1'b1;
              end else begin
                state_q <= StShift;
                busy_q  <= 1'b1;
              end
            end else if (mode == ModeLoad) begin
              q_q <= d;
            end else begin
              q_q <= step_op(mode, q_q, sin_l, sin_r);
            end
          end
        end
        StShift: begin
          // mode, d, amt and start are ignored here; en=0 simply pauses.
          if (en) begin
            q_q   <= step_op(op_q, q_q, sin_l, sin_r);
            cnt_q <= cnt_q - CntOne;
            if (cnt_q == CntOne) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q        = q_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  mode;
  logic [15:0] d;
  logic        sin_l;
  logic        sin_r;
  logic        start;
  logic [4:0]  amt;

  logic [7:0]  q8;
  logic        msb8, lsb8, busy8, done8;
  logic [15:0] q16;
  logic        msb16, lsb16, busy16, done16;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: index 0 = 8-bit instance, 1 = 16-bit instance.
  int unsigned mq[2];
  bit          mbusy[2];
  bit          mdone[2];
  int          mcnt[2];
  int          mop[2];
  int          mw[2] = '{8, 16};

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .d        (d[7:0]),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .start    (start),
    .amt      (amt[3:0]),
    .q        (q8),
    .sout_msb (msb8),
    .sout_lsb (lsb8),
    .busy     (busy8),
    .done     (done8)
  );

  univ_shift_reg #(.WIDTH(16), .AMT_W(5)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .start    (start),
    .amt      (amt),
    .q        (q16),
    .sout_msb (msb16),
    .sout_lsb (lsb16),
    .busy     (busy16),
    .done     (done16)
  );

  // Arithmetic view of one step on a w-bit unsigned value.
  function automatic int unsigned mstep(int w, int op, int unsigned cur, bit sl, bit sr);
    int unsigned full = 1 << w;
    int unsigned top  = 1 << (w - 1);
    case (op)
      2: return (cur * 2 + sr) % full;
      3: return cur / 2 + (sl ? top : 0);
      4: return (cur * 2) % full + cur / top;
      5: return cur / 2 + (cur % 2) * top;
      6: return cur / 2 + ((cur >= top) ? top : 0);
      7: return 0;
      default: return cur;
    endcase
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int a;
      int unsigned dd;
      a  = (i == 0) ? int'(amt[3:0]) : int'(amt);
      dd = (i == 0) ? int'(d[7:0]) : int'(d);
      if (reset) begin
        mq[i] = 0; mbusy[i] = 0; mdone[i] = 0; mcnt[i] = 0; mop[i] = 0;
      end else if (mbusy[i]) begin
        mdone[i] = 0;
        if (en) begin
          mq[i] = mstep(mw[i], mop[i], mq[i], sin_l, sin_r);
          mcnt[i]--;
          if (mcnt[i] == 0) begin
            mbusy[i] = 0;
            mdone[i] = 1;
          end
        end
      end else begin
        mdone[i] = 0;
        if (en) begin
          if (start && mode >= 2 && mode <= 6) begin
            mop[i]  = int'(mode);
            mcnt[i] = a;
            if (a == 0) mdone[i] = 1;
            else mbusy[i] = 1;
          end else if (mode == 1) begin
            mq[i] = dd;
          end else begin
            mq[i] = mstep(mw[i], int'(mode), mq[i], sin_l, sin_r);
          end
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q8", {8'h00, q8}, mq[0][15:0]);
    chk("msb8", {15'd0, msb8}, 16'(mq[0] / 128));
    chk("lsb8", {15'd0, lsb8}, 16'(mq[0] % 2));
    chk("busy8", {15'd0, busy8}, {15'd0, mbusy[0]});
    chk("done8", {15'd0, done8}, {15'd0, mdone[0]});
    chk("q16", q16, mq[1][15:0]);
    chk("msb16", {15'd0, msb16}, 16'(mq[1] / 32768));
    chk("lsb16", {15'd0, lsb16}, 16'(mq[1] % 2));
    chk("busy16", {15'd0, busy16}, {15'd0, mbusy[1]});
    chk("done16", {15'd0, done16}, {15'd0, mdone[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(bit r, bit e, logic [2:0] m, logic [15:0] dv, bit st, logic [4:0] a,
                       bit sl, bit sr);
    reset = r; en = e; mode = m; d = dv; start = st; amt = a; sin_l = sl; sin_r = sr;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mbusy[i] = 0; mdone[i] = 0; mcnt[i] = 0; mop[i] = 0;
    end
    drive(1, 0, 3'b000, 16'h0000, 0, 5'd0, 0, 0);

    // Reset, load, enable-gated hold.
    tick(); tick();
    chk("tp1_reset_q", {8'h00, q8}, 16'h0000);
    drive(0, 1, 3'b001, 16'h00A5, 0, 5'd0, 0, 0); tick();
    chk("tp1_load", {8'h00, q8}, 16'h00A5);
    drive(0, 0, 3'b001, 16'h00FF, 0, 5'd0, 0, 0); tick();
    chk("tp1_hold", {8'h00, q8}, 16'h00A5);

    // Single-step ops.
    drive(0, 1, 3'b010, 16'h0000, 0, 5'd0, 0, 1); tick();
    chk("tp2_shl", {8'h00, q8}, 16'h004B);
    drive(0, 1, 3'b101, 16'h0000, 0, 5'd0, 0, 1); tick();
    chk("tp2_rotr", {8'h00, q8}, 16'h00A5);
    drive(0, 1, 3'b110, 16'h0000, 0, 5'd0, 0, 1); tick();
    chk("tp2_ashr", {8'h00, q8}, 16'h00D2);
    drive(0, 1, 3'b111, 16'h0000, 0, 5'd0, 0, 1); tick();
    chk("tp2_clear", {8'h00, q8}, 16'h0000);

    // Multi-cycle rotl by 3 with ignored mode/d changes while busy.
    drive(0, 1, 3'b001, 16'h0081, 0, 5'd0, 0, 0); tick();
    drive(0, 1, 3'b100, 16'h0000, 1, 5'd3, 0, 0); tick();
    chk("tp3_latch_q", {8'h00, q8}, 16'h0081);
    drive(0, 1, 3'b001, 16'h00FF, 0, 5'd0, 0, 0); tick();
    chk("tp3_step1", {8'h00, q8}, 16'h0003);
    drive(0, 1, 3'b111, 16'h0055, 1, 5'd7, 0, 0); tick();
    chk("tp3_step2", {8'h00, q8}, 16'h0006);
    tick();
    chk("tp3_step3", {8'h00, q8}, 16'h000C);
    chk("tp3_done", {15'd0, done8}, 16'h0001);
    drive(0, 1, 3'b000, 16'h0000, 0, 5'd0, 0, 0); tick();
    chk("tp3_done_clr", {15'd0, done8}, 16'h0000);

    // ashr by 2 with a pause.
    drive(0, 1, 3'b001, 16'h0090, 0, 5'd0, 0, 0); tick();
    drive(0, 1, 3'b110, 16'h0000, 1, 5'd2, 0, 0); tick();
    drive(0, 1, 3'b000, 16'h0000, 0, 5'd0, 0, 0); tick();
    chk("tp4_step1", {8'h00, q8}, 16'h00C8);
    drive(0, 0, 3'b000, 16'h0000, 0, 5'd0, 0, 0); tick();
    chk("tp4_pause", {8'h00, q8}, 16'h00C8);
    chk("tp4_busy_pause", {15'd0, busy8}, 16'h0001);
    drive(0, 1, 3'b000, 16'h0000, 0, 5'd0, 0, 0); tick();
    chk("tp4_step2", {8'h00, q8}, 16'h00E4);
    tick();

    // Reset mid-sequence, then amt=0 start.
    drive(0, 1, 3'b001, 16'h00FF, 0, 5'd0, 0, 0); tick();
    drive(0, 1, 3'b010, 16'h0000, 1, 5'd5, 0, 0); tick();
    drive(0, 1, 3'b000, 16'h0000, 0, 5'd0, 0, 0); tick();
    drive(1, 1, 3'b000, 16'h0000, 0, 5'd0, 0, 0); tick();
    chk("tp5_reset_q", {8'h00, q8}, 16'h0000);
    drive(0, 1, 3'b000, 16'h0000, 0, 5'd0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    drive(0, 1, 3'b001, 16'h003C, 0, 5'd0, 0, 0); tick();
    drive(0, 1, 3'b010, 16'h0000, 1, 5'd0, 0, 1); tick();
    chk("tp5_amt0_q", {8'h00, q8}, 16'h003C);
    chk("tp5_amt0_done", {15'd0, done8}, 16'h0001);
    chk("tp5_amt0_busy", {15'd0, busy8}, 16'h0000);
    drive(0, 1, 3'b000, 16'h0000, 0, 5'd0, 0, 0); tick();

    // 16-bit shr by 17 (> WIDTH) with sin_l=1.
    drive(0, 1, 3'b001, 16'h8001, 0, 5'd0, 0, 0); tick();
    drive(0, 1, 3'b011, 16'h0000, 1, 5'd17, 1, 0); tick();
    drive(0, 1, 3'b000, 16'h0000, 0, 5'd0, 1, 0);
    for (int i = 0; i < 17; i++) tick();
    chk("tp6_q16", q16, 16'hFFFF);
    chk("tp6_done16", {15'd0, done16}, 16'h0001);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), 3'($urandom),
            16'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 20)),
            1'($urandom), 1'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
